// File: rtl/lpddr2_port_arbiter.sv
// Round-robin arbiter sharing one LPDDR2 command port between fetch (A) and data (B) ports.
// Optional watchdog: define LPDDR2_TIMEOUT_EN to abort stuck transactions and pulse err.
module lpddr2_port_arbiter #(
  parameter int ADDR_W         = 27,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_done,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_done,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              write_req,
  output logic              read_req,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_valid,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_RESP} state_t;
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;

  state_t            r_state;
  port_t             r_owner;
  port_t             r_last_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_write_data;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;
  logic              r_read_req;
  logic              r_write_req;
  logic              r_a_done;
  logic              r_b_done;

  port_t             w_grant;
  logic              w_grant_we;
  logic              w_busy;
  logic              w_accept;
  logic              w_wr_hit;
  logic              w_rd_hit;
  logic              w_timeout;
  logic              w_finish;
  logic [DATA_W-1:0] w_rdata_next;

  // Lone requester wins; on a tie the port not served last time wins.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_grant = PORT_A;
    if (a_req && b_req) w_grant = (r_last_grant == PORT_A) ? PORT_B : PORT_A;
    else if (b_req)     w_grant = PORT_B;
  end

  assign w_grant_we = (w_grant == PORT_B) && b_we;
  assign w_busy     = (r_state == S_ISSUE) || (r_state == S_WAIT_RD);
  assign w_accept   = (r_state == S_ISSUE) && mem_ready;
  assign w_wr_hit   = r_we && w_accept;
  assign w_rd_hit   = !r_we && read_valid && (w_accept || (r_state == S_WAIT_RD));
  assign w_finish   = w_wr_hit || w_rd_hit || w_timeout;

`ifdef LPDDR2_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] TMO_RDATA = DATA_W'(32'hDEADBEEF);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_err;

  // A real completion in the final cycle beats the watchdog.
  assign w_timeout    = w_busy && !w_wr_hit && !w_rd_hit && (r_tmo_cnt == TMO_LAST);
  assign w_rdata_next = w_timeout ? TMO_RDATA : read_data;
  assign err          = r_err;

  // Counter idles at zero outside ISSUE/WAIT_RD, so every ISSUE entry starts from 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (!w_busy)                    r_tmo_cnt <= '0;
      else if (r_tmo_cnt != TMO_LAST) r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  logic w_unused_tmo;

  assign w_timeout    = 1'b0;
  assign w_rdata_next = read_data;
  assign err          = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

  // NOTE: data and rdata holding registers are reset too, so every output reads 0 during rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_owner      <= PORT_A;
      r_last_grant <= PORT_A;
      r_we         <= 1'b0;
      r_address    <= '0;
      r_write_data <= '0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
      r_read_req   <= 1'b0;
      r_write_req  <= 1'b0;
      r_a_done     <= 1'b0;
      r_b_done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every branch sees the pre-edge state.
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (a_req || b_req) begin
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_we         <= w_grant_we;
            r_address    <= (w_grant == PORT_B) ? b_addr : a_addr;
            if (w_grant_we) r_write_data <= b_wdata;
            r_read_req   <= !w_grant_we;
            r_write_req  <= w_grant_we;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT_RD: begin
          if (w_accept || w_timeout) begin
            r_read_req  <= 1'b0;
            r_write_req <= 1'b0;
          end
          if (w_finish) begin
            r_state  <= S_RESP;
            r_a_done <= (r_owner == PORT_A);
            r_b_done <= (r_owner == PORT_B);
            if (!r_we) begin
              if (r_owner == PORT_A) r_a_rdata <= w_rdata_next;
              else                   r_b_rdata <= w_rdata_next;
            end
          end else if (w_accept) begin
            r_state <= S_WAIT_RD;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign address    = r_address;
  assign write_data = r_write_data;
  assign read_req   = r_read_req;
  assign write_req  = r_write_req;
  assign a_rdata    = r_a_rdata;
  assign b_rdata    = r_b_rdata;
  assign a_done     = r_a_done;
  assign b_done     = r_b_done;

endmodule
